// File: rtl/mult_share_pkg.sv
// rtl/mult_share_pkg.sv - shared state encoding and default sizes for the multiplier-share arbiter
package mult_share_pkg;

  localparam int N_REQ_DEF  = 4;
  localparam int L_WORD_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mult_rr_pick.sv
// rtl/mult_rr_pick.sv - combinational round-robin picker, priority starts just after i_last
module mult_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_last,
  output logic [N_REQ-1:0] o_win,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  int           w_j;
  logic [IW-1:0] w_jj;

  always_comb begin
    o_any = 1'b0;
    o_idx = '0;
    o_win = '0;
    w_j   = 0;
    w_jj  = '0;
    // Offsets 1..N_REQ walk from the slot after the last grant, wrapping back to it last.
    for (int k = 1; k <= N_REQ; k++) begin
      w_j  = (int'(i_last) + k) % N_REQ;
      w_jj = IW'(w_j);
      if (!o_any && i_req[w_jj]) begin
        o_any = 1'b1;
        o_idx = w_jj;
        o_win = N_REQ'(1) << w_jj;
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin scheduler sharing one Start/Ready shift-add multiplier
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int L_word = L_WORD_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ*L_word-1:0] i_a_bus,
  input  logic [N_REQ*L_word-1:0] i_b_bus,
  output logic [N_REQ-1:0]        o_grant,
  output logic [N_REQ-1:0]        o_done,
  output logic [2*L_word:0]       o_result,
  output logic                    o_busy,
  output logic [L_word-1:0]       o_mult_word1,
  output logic [L_word-1:0]       o_mult_word2,
  output logic                    o_mult_start,
  input  logic                    i_mult_ready,
  input  logic [2*L_word:0]       i_mult_product
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PW = 2 * L_word + 1;

  state_t            r_state;
  state_t            w_next;
  logic [N_REQ-1:0]  r_grant;
  logic [IW-1:0]     r_last;
  logic [L_word-1:0] r_word1;
  logic [L_word-1:0] r_word2;
  logic [PW-1:0]     r_result;

  logic [N_REQ-1:0]  w_win;
  logic [IW-1:0]     w_idx;
  logic              w_any;
  logic              w_take;
  logic [L_word-1:0] w_a;
  logic [L_word-1:0] w_b;

  mult_rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .i_req  (i_req),
    .i_last (r_last),
    .o_win  (w_win),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  assign w_a    = i_a_bus[w_idx*L_word +: L_word];
  assign w_b    = i_b_bus[w_idx*L_word +: L_word];
  assign w_take = (r_state == S_IDLE) && w_any && i_mult_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_take) w_next = S_ISSUE;
      S_ISSUE: w_next = S_BUSY;
      // Ready may already be high here (zero operand flush) or low (job running).
      S_BUSY:  if (i_mult_ready) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy       = (r_state != S_IDLE);
    o_mult_start = (r_state == S_ISSUE);
    o_done       = (r_state == S_DONE) ? r_grant : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_grant  <= '0;
      r_last   <= IW'(N_REQ - 1);
      r_word1  <= '0;
      r_word2  <= '0;
      r_result <= '0;
    end else begin
      if (w_take) begin
        r_grant <= w_win;
        r_last  <= w_idx;
        r_word1 <= w_a;
        r_word2 <= w_b;
      end
      if ((r_state == S_BUSY) && i_mult_ready) r_result <= i_mult_product;
      if (r_state == S_DONE) r_grant <= '0;
    end
  end

  assign o_grant      = r_grant;
  assign o_result     = r_result;
  assign o_mult_word1 = r_word1;
  assign o_mult_word2 = r_word2;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - scoreboard bench for mult_share_arbiter with a behavioural multiplier
module tb_mult_share_arbiter;

  localparam int N  = 4;
  localparam int LW = 4;
  localparam int PW = 2 * LW + 1;

  typedef struct {
    int idx;
    int res;
    int lat;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*LW-1:0] a_bus;
  logic [N*LW-1:0] b_bus;
  logic [N-1:0]    grant;
  logic [N-1:0]    done;
  logic [PW-1:0]   result;
  logic            busy;
  logic [LW-1:0]   w1;
  logic [LW-1:0]   w2;
  logic            start;
  logic            m_ready;
  logic [PW-1:0]   m_prod;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   grant_cyc = 0;
  int   n_done   = 0;
  logic [N-1:0] last_done = '0;
  logic [N-1:0] prev_grant = '0;
  logic start_pending = 1'b0;
  logic ready_low_seen = 1'b0;
  exp_t sb[$];

  mult_share_arbiter #(.N_REQ(N), .L_word(LW)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_req          (req),
    .i_a_bus        (a_bus),
    .i_b_bus        (b_bus),
    .o_grant        (grant),
    .o_done         (done),
    .o_result       (result),
    .o_busy         (busy),
    .o_mult_word1   (w1),
    .o_mult_word2   (w2),
    .o_mult_start   (start),
    .i_mult_ready   (m_ready),
    .i_mult_product (m_prod)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: Ready drops the edge after Start (nonzero operands), rises 5 edges later.
  int            m_cnt;
  logic [PW-1:0] m_acc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready <= 1'b1;
      m_prod  <= '0;
      m_cnt   <= 0;
      m_acc   <= '0;
    end else if (m_ready) begin
      if (start) begin
        if (w1 == 0 || w2 == 0) begin
          m_prod <= '0;
        end else begin
          m_ready <= 1'b0;
          m_cnt   <= 5;
          m_acc   <= PW'(w1) * PW'(w2);
        end
      end
    end else begin
      if (m_cnt == 1) begin
        m_ready <= 1'b1;
        m_prod  <= m_acc;
      end
      m_cnt <= m_cnt - 1;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!m_ready) ready_low_seen = 1'b1;
    if (start_pending) begin
      chk("start_pulse_end", int'(start), 0);
      start_pending = 1'b0;
    end
    if (grant != 0 && prev_grant == 0) begin
      grant_cyc = cyc;
      chk("start_at_grant", int'(start), 1);
      start_pending = 1'b1;
    end
    prev_grant = grant;
    if (done != 0) begin
      n_done++;
      last_done = done;
      if (sb.size() == 0) begin
        chk("unexpected_done", int'(done), 0);
      end else begin
        e = sb.pop_front();
        chk("done_onehot", int'(done), 1 << e.idx);
        chk("result", int'(result), e.res);
        chk("latency", cyc - grant_cyc, e.lat);
        chk("grant_at_done", int'(grant), int'(done));
      end
    end
  end

  task automatic push(input int idx, input int res, input int lat);
    exp_t e;
    e.idx = idx; e.res = res; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic set_op(input int i, input int a, input int b);
    a_bus[i*LW +: LW] = LW'(a);
    b_bus[i*LW +: LW] = LW'(b);
  endtask

  task automatic wait_dones(input int target, input int budget);
    int k;
    k = 0;
    while (n_done < target && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    if (n_done < target) chk("timeout_done", n_done, target);
  endtask

  task automatic wait_grant(input int budget);
    int k;
    k = 0;
    while (grant == 0 && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    if (grant == 0) chk("timeout_grant", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_grant"}, int'(grant), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_result"}, int'(result), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_start"}, int'(start), 0);
    chk({tag, "_word1"}, int'(w1), 0);
    chk({tag, "_word2"}, int'(w2), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    req   = '0;
    a_bus = '0;
    b_bus = '0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;

    // Single nonzero job from reset: req[0] has first priority.
    @(negedge clk);
    set_op(0, 3, 5);
    push(0, 15, 7);
    req[0] = 1'b1;
    wait_dones(1, 30);
    req[0] = 1'b0;

    // Zero operand: flushed product, Ready never drops.
    @(negedge clk);
    ready_low_seen = 1'b0;
    set_op(1, 0, 9);
    push(1, 0, 2);
    req[1] = 1'b1;
    wait_dones(2, 30);
    req[1] = 1'b0;
    chk("zero_ready_stayed_high", int'(ready_low_seen), 0);

    // Four simultaneous requesters after reset: served 0,1,2,3.
    do_reset();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      set_op(i, i + 1, 15);
      push(i, (i + 1) * 15, 7);
    end
    req  = '1;
    base = n_done;
    for (int k = 1; k <= N; k++) begin
      wait_dones(base + k, 30);
      req = req & ~last_done;
    end

    // req[0] and req[2] held continuously: grants alternate.
    @(negedge clk);
    set_op(0, 2, 3);
    set_op(2, 4, 5);
    for (int k = 0; k < 3; k++) begin
      push(0, 6, 7);
      push(2, 20, 7);
    end
    base = n_done;
    req  = 4'b0101;
    wait_dones(base + 6, 80);
    req  = '0;

    // Reset at E4 of a 15x15 job: no done, all outputs cleared at once.
    repeat (3) @(negedge clk);
    set_op(3, 15, 15);
    req[3] = 1'b1;
    wait_grant(20);
    repeat (4) @(posedge clk);
    #1;
    base  = n_done;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midjob");
    repeat (3) @(negedge clk);
    chk("no_done_after_abort", n_done, base);
    push(3, 225, 7);
    rst_n = 1'b1;
    wait_dones(base + 1, 30);
    req[3] = 1'b0;

    // Operand change after the grant edge must not affect the running job.
    @(negedge clk);
    set_op(2, 7, 9);
    push(2, 63, 7);
    req[2] = 1'b1;
    wait_grant(20);
    base = n_done;
    repeat (2) @(posedge clk);
    #1;
    set_op(2, 0, 9);
    wait_dones(base + 1, 30);
    req[2] = 1'b0;

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected %0d", cyc, 0);
    $fatal(1, "global timeout");
  end

endmodule
